multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the RV32 subset datapath: ADDI/ANDI/ORI, R-type ALU, LW, LH, SW, SH, BEQ, BNE and JAL.

---
 rtl/ctrl_pkg.sv | 52 +++++
 rtl/ctrl_opdecode.sv | 43 ++++
 rtl/multicycle_ctrl.sv | 171 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and datapath-select encodings for the multicycle control
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_ALU,
    EXEC_ADDR,
    EXEC_BR,
    EXEC_JAL,
    MEM,
    WB_ALU,
    WB_MEM,
    TRAP
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_MEM,
    CLS_BR,
    CLS_JAL
  } op_class_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_LH     = 7'b0001011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_SH     = 7'b0101011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] WBSEL_ALU = 2'b00;
  localparam logic [1:0] WBSEL_MEM = 2'b01;
  localparam logic [1:0] WBSEL_PC4 = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/ctrl_opdecode.sv
// rtl/ctrl_opdecode.sv - combinational opcode classifier for the multicycle control
module ctrl_opdecode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class,
  output logic       is_store,
  output logic       is_half,
  output logic       is_itype,
  output logic       legal
);

  // classify the IR opcode; anything not listed is illegal
  always_comb begin
    op_class = CLS_ALU;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_itype = 1'b0;
    legal    = 1'b1;
    case (opcode)
      OP_RTYPE:  op_class = CLS_ALU;
      OP_ITYPE:  is_itype = 1'b1;
      OP_LW:     op_class = CLS_MEM;
      OP_LH: begin
        op_class = CLS_MEM;
        is_half  = 1'b1;
      end
      OP_SW: begin
        op_class = CLS_MEM;
        is_store = 1'b1;
      end
      OP_SH: begin
        op_class = CLS_MEM;
        is_store = 1'b1;
        is_half  = 1'b1;
      end
      OP_BRANCH: op_class = CLS_BR;
      OP_JAL:    op_class = CLS_JAL;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32-subset control FSM with handshaked memory port
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT  = 255,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_half,
  output logic                addr_sel,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_write,
  output logic [1:0]          wb_sel,
  output logic                illegal,
  output logic                bus_err,
  output logic [RETIRE_W-1:0] retired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  state_t          state, nxt;
  logic            active;
  logic [CW-1:0]   wait_cnt;
  logic            retire, set_illegal, set_buserr, timeout_hit;
  op_class_t       op_class;
  logic            is_store, is_half, is_itype, legal;

  ctrl_opdecode u_dec (
    .opcode   (opcode),
    .op_class (op_class),
    .is_store (is_store),
    .is_half  (is_half),
    .is_itype (is_itype),
    .legal    (legal)
  );

  // the TIMEOUT-th consecutive unanswered request cycle is the last one allowed
  assign timeout_hit = !mem_ready && (wait_cnt == LAST_WAIT);

  // next state and datapath selects decoded from the current state
  always_comb begin
    nxt         = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_half    = 1'b0;
    addr_sel    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_PLUS4;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALUOP_ADD;
    reg_write   = 1'b0;
    wb_sel      = WBSEL_ALU;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_buserr  = 1'b0;
    case (state)
      FETCH: begin
        // active is low while reset is held, keeping the bus quiet until release
        if (active) begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            nxt      = DECODE;
          end else if (timeout_hit) begin
            set_buserr = 1'b1;
            nxt        = TRAP;
          end
        end
      end
      DECODE: begin
        if (!legal) begin
          set_illegal = 1'b1;
          nxt         = TRAP;
        end else begin
          case (op_class)
            CLS_ALU: nxt = EXEC_ALU;
            CLS_MEM: nxt = EXEC_ADDR;
            CLS_BR:  nxt = EXEC_BR;
            default: nxt = EXEC_JAL;
          endcase
        end
      end
      EXEC_ALU: begin
        alu_op    = ALUOP_FUNCT;
        alu_src_b = is_itype ? SRCB_IMM : SRCB_RS2;
        nxt       = WB_ALU;
      end
      EXEC_ADDR: begin
        alu_src_b = SRCB_IMM;
        nxt       = MEM;
      end
      EXEC_BR: begin
        alu_op = ALUOP_SUB;
        pc_src = PC_BRANCH;
        if (funct3 == F3_BEQ) pc_write = zero;
        else if (funct3 == F3_BNE) pc_write = !zero;
        retire = 1'b1;
        nxt    = FETCH;
      end
      EXEC_JAL: begin
        reg_write = 1'b1;
        wb_sel    = WBSEL_PC4;
        pc_write  = 1'b1;
        pc_src    = PC_JAL;
        retire    = 1'b1;
        nxt       = FETCH;
      end
      MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        mem_half = is_half;
        if (mem_ready) begin
          retire = is_store;
          nxt    = is_store ? FETCH : WB_MEM;
        end else if (timeout_hit) begin
          set_buserr = 1'b1;
          nxt        = TRAP;
        end
      end
      WB_ALU: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        nxt       = FETCH;
      end
      WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = WBSEL_MEM;
        retire    = 1'b1;
        nxt       = FETCH;
      end
      TRAP: nxt = TRAP;
      default: nxt = FETCH;
    endcase
  end

  // state, wait counter, retire counter and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      active   <= 1'b0;
      wait_cnt <= '0;
      retired  <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= nxt;
      active   <= 1'b1;
      wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1'b1 : '0;
      retired  <= retired + {{(RETIRE_W-1){1'b0}}, retire};
      illegal  <= illegal | set_illegal;
      bus_err  <= bus_err | set_buserr;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, mem_half, addr_sel, ir_write, pc_write, reg_write;
  logic [1:0] pc_src, alu_src_b, alu_op, wb_sel;
  logic       illegal, bus_err;
  logic [2:0] retired;
  logic [14:0] outs;

  int total = 0;
  int bad   = 0;

  // output bundle: mem_req,mem_we,mem_half,addr_sel,ir_write,pc_write,pc_src,alu_src_b,alu_op,reg_write,wb_sel
  localparam logic [14:0] F_RDY  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00};
  localparam logic [14:0] F_WAIT = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00};
  localparam logic [14:0] DEC    = 15'b0;
  localparam logic [14:0] EX_I   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 2'b00};
  localparam logic [14:0] EX_R   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 2'b00};
  localparam logic [14:0] EX_AD  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 2'b00};
  localparam logic [14:0] M_LH   = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00};
  localparam logic [14:0] M_SW   = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00};
  localparam logic [14:0] M_SH   = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00};
  localparam logic [14:0] WB_A   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00};
  localparam logic [14:0] WB_M   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01};
  localparam logic [14:0] BR_NT  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 2'b00};
  localparam logic [14:0] BR_T   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b01, 1'b0, 2'b00};
  localparam logic [14:0] JALO   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b1, 2'b10};

  assign outs = {mem_req, mem_we, mem_half, addr_sel, ir_write, pc_write,
                 pc_src, alu_src_b, alu_op, reg_write, wb_sel};

  multicycle_ctrl #(.TIMEOUT(4), .RETIRE_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct3    (funct3),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_half  (mem_half),
    .addr_sel  (addr_sel),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .illegal   (illegal),
    .bus_err   (bus_err),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cyc(input logic rdy, input logic z);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    zero = z;
    @(negedge clk);
  endtask

  task automatic test_reset();
    opcode = 7'b0010011;
    funct3 = 3'b000;
    do_reset();
    total++;
    if ({outs, illegal, bus_err} !== 17'b0) begin
      bad++;
      $display("FAIL reset_outs got=%b want=0", {outs, illegal, bus_err});
    end
    total++;
    if (retired !== 3'd0) begin
      bad++;
      $display("FAIL reset_retired got=%0d want=0", retired);
    end
    cyc(1'b0, 1'b0);
    total++;
    if (outs !== F_WAIT) begin
      bad++;
      $display("FAIL reset_first_fetch got=%b want=%b", outs, F_WAIT);
    end
  endtask

  task automatic test_alu();
    logic [14:0] ei [4];
    logic [14:0] er [4];
    ei = '{F_RDY, DEC, EX_I, WB_A};
    er = '{F_RDY, DEC, EX_R, WB_A};
    do_reset();
    opcode = 7'b0010011;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0);
      total++;
      if (outs !== ei[i]) begin
        bad++;
        $display("FAIL addi_c%0d got=%b want=%b", i + 1, outs, ei[i]);
      end
    end
    total++;
    if (retired !== 3'd0) begin
      bad++;
      $display("FAIL addi_retired_before got=%0d want=0", retired);
    end
    cyc(1'b0, 1'b0);
    total++;
    if (outs !== F_WAIT || retired !== 3'd1) begin
      bad++;
      $display("FAIL addi_retired_after got=%b/%0d want=%b/1", outs, retired, F_WAIT);
    end
    opcode = 7'b0110011;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0);
      total++;
      if (outs !== er[i]) begin
        bad++;
        $display("FAIL rtype_c%0d got=%b want=%b", i + 1, outs, er[i]);
      end
    end
    cyc(1'b0, 1'b0);
    total++;
    if (retired !== 3'd2) begin
      bad++;
      $display("FAIL rtype_retired got=%0d want=2", retired);
    end
  endtask

  task automatic test_load_half();
    logic [14:0] e [8];
    logic [7:0]  rdy;
    e = '{F_RDY, DEC, EX_AD, M_LH, M_LH, M_LH, M_LH, WB_M};
    rdy = 8'b1100_0111;
    do_reset();
    opcode = 7'b0001011;
    for (int i = 0; i < 8; i++) begin
      cyc(rdy[i], 1'b0);
      total++;
      if (outs !== e[i]) begin
        bad++;
        $display("FAIL lh_c%0d got=%b want=%b", i + 1, outs, e[i]);
      end
    end
    cyc(1'b0, 1'b0);
    total++;
    if (outs !== F_WAIT || retired !== 3'd1) begin
      bad++;
      $display("FAIL lh_done got=%b/%0d want=%b/1", outs, retired, F_WAIT);
    end
  endtask

  task automatic test_store();
    logic [14:0] e [4];
    do_reset();
    e = '{F_RDY, DEC, EX_AD, M_SW};
    opcode = 7'b0100011;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0);
      total++;
      if (outs !== e[i]) begin
        bad++;
        $display("FAIL sw_c%0d got=%b want=%b", i + 1, outs, e[i]);
      end
    end
    e = '{F_RDY, DEC, EX_AD, M_SH};
    opcode = 7'b0101011;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0);
      total++;
      if (outs !== e[i]) begin
        bad++;
        $display("FAIL sh_c%0d got=%b want=%b", i + 1, outs, e[i]);
      end
    end
    cyc(1'b0, 1'b0);
    total++;
    if (outs !== F_WAIT || retired !== 3'd2) begin
      bad++;
      $display("FAIL store_done got=%b/%0d want=%b/2", outs, retired, F_WAIT);
    end
  endtask

  task automatic test_branch();
    logic [2:0]  f3 [4];
    logic        zf [4];
    logic [14:0] eb [4];
    f3 = '{3'b000, 3'b001, 3'b010, 3'b000};
    zf = '{1'b0, 1'b0, 1'b1, 1'b1};
    eb = '{BR_NT, BR_T, BR_NT, BR_T};
    do_reset();
    opcode = 7'b1100011;
    for (int k = 0; k < 4; k++) begin
      funct3 = f3[k];
      cyc(1'b1, zf[k]);
      total++;
      if (outs !== F_RDY || retired !== 3'(k)) begin
        bad++;
        $display("FAIL br%0d_fetch got=%b/%0d want=%b/%0d", k, outs, retired, F_RDY, k);
      end
      cyc(1'b1, zf[k]);
      cyc(1'b1, zf[k]);
      total++;
      if (outs !== eb[k]) begin
        bad++;
        $display("FAIL br%0d_exec got=%b want=%b", k, outs, eb[k]);
      end
    end
    cyc(1'b0, 1'b0);
    total++;
    if (retired !== 3'd4) begin
      bad++;
      $display("FAIL br_retired got=%0d want=4", retired);
    end
    funct3 = 3'b000;
  endtask

  task automatic test_back_to_back_jal();
    do_reset();
    opcode = 7'b1101111;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0);
      total++;
      if (outs !== F_RDY || retired !== 3'(i)) begin
        bad++;
        $display("FAIL jal%0d_fetch got=%b/%0d want=%b/%0d", i, outs, retired, F_RDY, i);
      end
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      total++;
      if (outs !== JALO) begin
        bad++;
        $display("FAIL jal%0d_exec got=%b want=%b", i, outs, JALO);
      end
    end
    cyc(1'b0, 1'b0);
    total++;
    if (outs !== F_WAIT || retired !== 3'd0) begin
      bad++;
      $display("FAIL jal_wrap got=%b/%0d want=%b/0", outs, retired, F_WAIT);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 7'b1111111;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    total++;
    if (outs !== DEC || illegal !== 1'b0) begin
      bad++;
      $display("FAIL ill_decode got=%b/%b want=%b/0", outs, illegal, DEC);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1'(i % 2), 1'(i / 2 % 2));
      total++;
      if (outs !== 15'b0 || illegal !== 1'b1 || bus_err !== 1'b0) begin
        bad++;
        $display("FAIL ill_trap%0d got=%b/%b/%b want=0/1/0", i, outs, illegal, bus_err);
      end
    end
    do_reset();
    total++;
    if (illegal !== 1'b0) begin
      bad++;
      $display("FAIL ill_reset got=%b want=0", illegal);
    end
    opcode = 7'b0010011;
    cyc(1'b0, 1'b0);
    total++;
    if (outs !== F_WAIT) begin
      bad++;
      $display("FAIL ill_restart got=%b want=%b", outs, F_WAIT);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = 7'b0010011;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0);
      total++;
      if (outs !== F_WAIT || bus_err !== 1'b0) begin
        bad++;
        $display("FAIL to_wait%0d got=%b/%b want=%b/0", i, outs, bus_err, F_WAIT);
      end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0);
      total++;
      if (outs !== 15'b0 || bus_err !== 1'b1) begin
        bad++;
        $display("FAIL to_trap%0d got=%b/%b want=0/1", i, outs, bus_err);
      end
    end
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    total++;
    if (outs !== F_RDY) begin
      bad++;
      $display("FAIL to_last_ready got=%b want=%b", outs, F_RDY);
    end
    cyc(1'b1, 1'b0);
    total++;
    if (outs !== DEC || bus_err !== 1'b0) begin
      bad++;
      $display("FAIL to_no_err got=%b/%b want=%b/0", outs, bus_err, DEC);
    end
    do_reset();
    opcode = 7'b0001011;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    total++;
    if (outs !== M_LH) begin
      bad++;
      $display("FAIL rst_mem_pre got=%b want=%b", outs, M_LH);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rst_mem_same got=%b want=1", mem_req);
    end
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || outs !== 15'b0) begin
      bad++;
      $display("FAIL rst_mem_drop got=%b want=0", outs);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    opcode = 7'b0010011;
    funct3 = 3'b000;
    zero = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_alu();
    test_load_half();
    test_store();
    test_branch();
    test_back_to_back_jal();
    test_illegal();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
